// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and the reference round-robin selection for the SDRAM bank arbiter.
// Optional build macro used by the arbiter: JTFRAME_SDRAM_ARB_PRIO_EN.
package jtframe_sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_st_t;

  localparam int ARB_MAXCH = 8;

  // First requesting channel after 'last', wrapping at ch-1.
  function automatic logic [2:0] rr_next(
    input logic [ARB_MAXCH-1:0] req,
    input logic [2:0]           last,
    input int unsigned          ch
  );
    logic       found;
    int unsigned idx;
    rr_next = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= ARB_MAXCH; k++) begin
      idx = (int'(last) + k) % ch;
      if (!found && k <= ch && req[idx]) begin
        rr_next = 3'(idx);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Rotate-mask priority encoder: lowest request above 'last',
// otherwise lowest request overall.
module jtframe_rr_pick #(
  parameter  int CH  = 4,
  localparam int CHW = $clog2(CH)
) (
  input  logic [CH-1:0]  req,
  input  logic [CHW-1:0] last,
  output logic [CHW-1:0] gnt,
  output logic           vld
);

  logic [CH-1:0] mask;
  logic [CH-1:0] hi;

  always_comb begin
    mask = '0;
    for (int i = 0; i < CH; i++) begin
      if (i > int'(last)) mask[i] = 1'b1;
    end
    hi  = req & mask;
    vld = |req;
    gnt = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (req[i]) gnt = CHW'(i);
    end
    for (int i = CH - 1; i >= 0; i--) begin
      if (hi[i]) gnt = CHW'(i);
    end
  end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin N-channel arbiter in front of one SDRAM bank port.
// Define JTFRAME_SDRAM_ARB_PRIO_EN to give channel 0 fixed top priority.
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int CH     = 4
) (
  input  logic               rst,
  input  logic               clk,
  input  logic [CH*SDRAMW-1:0] ch_addr,
  input  logic [CH-1:0]      ch_rd,
  input  logic [CH-1:0]      ch_wr,
  input  logic [CH*16-1:0]   ch_din,
  input  logic [CH*2-1:0]    ch_dsn,
  output logic [CH-1:0]      ch_ack,
  output logic [CH-1:0]      ch_rdy,
  output logic [CH*16-1:0]   ch_dout,
  output logic [SDRAMW-1:0]  ba_addr,
  output logic               ba_rd,
  output logic               ba_wr,
  output logic [15:0]        ba_din,
  output logic [1:0]         ba_dsn,
  input  logic               ba_ack,
  input  logic               ba_rdy,
  input  logic [15:0]        sdram_dout
);

  localparam int CHW = $clog2(CH);

  arb_st_t            st_q, st_d;
  logic [CHW-1:0]     gnt_q, gnt_d;
  logic [CHW-1:0]     last_q, last_d;
  logic               wr_q, wr_d;
  logic [SDRAMW-1:0]  ba_addr_q, ba_addr_d;
  logic [15:0]        ba_din_q, ba_din_d;
  logic [1:0]         ba_dsn_q, ba_dsn_d;
  logic               ba_rd_q, ba_rd_d;
  logic               ba_wr_q, ba_wr_d;
  logic [CH-1:0]      ch_ack_q, ch_ack_d;
  logic [CH-1:0]      ch_rdy_q, ch_rdy_d;
  logic [CH*16-1:0]   ch_dout_q, ch_dout_d;

  logic [CH-1:0]      req;
  logic [CH-1:0]      rr_req;
  logic               prio0;
  logic               upd_last;
  logic [CHW-1:0]     rr_gnt;
  logic               rr_vld;
  logic [CHW-1:0]     pick;
  logic               pick_vld;
  logic               done;

  assign req = ch_rd | ch_wr;

`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
  assign rr_req   = req & ~CH'(1);
  assign prio0    = req[0];
  assign upd_last = gnt_q != '0;
`else
  assign rr_req   = req;
  assign prio0    = 1'b0;
  assign upd_last = 1'b1;
`endif

  jtframe_rr_pick #(
    .CH   (CH)
  ) u_pick (
    .req  (rr_req),
    .last (last_q),
    .gnt  (rr_gnt),
    .vld  (rr_vld)
  );

  assign pick     = prio0 ? '0 : rr_gnt;
  assign pick_vld = prio0 | rr_vld;

  always_comb begin
    st_d      = st_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    wr_d      = wr_q;
    ba_addr_d = ba_addr_q;
    ba_din_d  = ba_din_q;
    ba_dsn_d  = ba_dsn_q;
    ba_rd_d   = ba_rd_q;
    ba_wr_d   = ba_wr_q;
    ch_ack_d  = '0;
    ch_rdy_d  = '0;
    ch_dout_d = ch_dout_q;
    done      = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d     = pick;
          wr_d      = ch_wr[pick];
          ba_wr_d   = ch_wr[pick];
          ba_rd_d   = ~ch_wr[pick];
          ba_addr_d = ch_addr[pick*SDRAMW +: SDRAMW];
          ba_din_d  = ch_din[pick*16 +: 16];
          ba_dsn_d  = ch_dsn[pick*2 +: 2];
          ch_ack_d[pick] = 1'b1;
          st_d      = REQ;
        end
      end
      REQ: begin
        if (ba_ack) begin
          ba_rd_d = 1'b0;
          ba_wr_d = 1'b0;
          st_d    = WAIT;
          done    = ba_rdy;
        end
      end
      WAIT: begin
        done = ba_rdy;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
    // Completion is shared by the WAIT path and the ack+rdy shortcut in REQ
    if (done) begin
      if (!wr_q) ch_dout_d[gnt_q*16 +: 16] = sdram_dout;
      ch_rdy_d[gnt_q] = 1'b1;
      if (upd_last) last_d = gnt_q;
      st_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      gnt_q     <= '0;
      last_q    <= CHW'(CH - 1);
      wr_q      <= 1'b0;
      ba_addr_q <= '0;
      ba_din_q  <= '0;
      ba_dsn_q  <= 2'b11;
      ba_rd_q   <= 1'b0;
      ba_wr_q   <= 1'b0;
      ch_ack_q  <= '0;
      ch_rdy_q  <= '0;
      ch_dout_q <= '0;
    end else begin
      st_q      <= st_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      ba_addr_q <= ba_addr_d;
      ba_din_q  <= ba_din_d;
      ba_dsn_q  <= ba_dsn_d;
      ba_rd_q   <= ba_rd_d;
      ba_wr_q   <= ba_wr_d;
      ch_ack_q  <= ch_ack_d;
      ch_rdy_q  <= ch_rdy_d;
      ch_dout_q <= ch_dout_d;
    end
  end

  assign ch_ack  = ch_ack_q;
  assign ch_rdy  = ch_rdy_q;
  assign ch_dout = ch_dout_q;
  assign ba_addr = ba_addr_q;
  assign ba_rd   = ba_rd_q;
  assign ba_wr   = ba_wr_q;
  assign ba_din  = ba_din_q;
  assign ba_dsn  = ba_dsn_q;

endmodule
